// File: rtl/updi_pkg.sv
// Shared UPDI constants and the block-writer state encoding.
// Used by the block writer and any other UPDI command block.
package updi_pkg;

    localparam logic [7:0] UPDI_SYNCH       = 8'h55;
    localparam logic [7:0] UPDI_ST_PTR_W    = 8'h69;
    localparam logic [7:0] UPDI_REPEAT_B    = 8'hA0;
    localparam logic [7:0] UPDI_ST_PTRINC_B = 8'h64;
    localparam logic [7:0] UPDI_ACK         = 8'h40;

    localparam logic [7:0] BLOCK_TYPE_DATA = 8'h00;
    localparam logic [7:0] BLOCK_TYPE_EOF  = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR,
        ST_PTR_ACK,
        ST_RPT,
        ST_ST,
        ST_DATA,
        ST_DATA_ACK,
        ST_FINISH
    } updi_block_writer_state;

endpackage

// File: rtl/updi_block_writer_if.sv
// Byte-wide link between the block writer and the UPDI UART PHY.
// TX: a byte moves on a rising clk edge where tx_valid && tx_ready; once tx_valid
// rises, tx_data is held unchanged until that transfer. RX: rx_valid is a one-cycle strobe.
interface updi_block_writer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

endinterface

// File: rtl/updi_ack_timer.sv
// Response-wait timer: counts from the cycle clear drops and flags timeout
// while the count sits at ACK_TIMEOUT-1.
module updi_ack_timer #(
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic timeout
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick && !timeout) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (count == LAST);

endmodule

// File: rtl/updi_block_writer.sv
// Writes one decoded program block to target memory as a UPDI
// ST_PTR / REPEAT / ST_PTR_INC sequence, checking the target ACKs.
module updi_block_writer
    import updi_pkg::*;
#(
    parameter int DATA_BLOCK_MAX_SIZE  = 64,
    parameter int DATA_BLOCK_ADDR_BITS = $clog2(DATA_BLOCK_MAX_SIZE),
    parameter int ACK_TIMEOUT          = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 ready,
    output logic                                 done,
    output logic                                 error,
    input  logic [7:0]                           block_length,
    input  logic [15:0]                          block_address,
    input  logic [7:0]                           block_type,
    input  logic [DATA_BLOCK_MAX_SIZE-1:0][7:0]  block_data,
    updi_block_writer_if.master                  link,
    output updi_block_writer_state               state_dbg
);

    updi_block_writer_state state, state_n;
    logic [1:0]  step, step_n;
    logic [7:0]  idx, idx_n, idx_inc;
    logic [7:0]  len, len_n, len_m1;
    logic [15:0] addr, addr_n;
    logic        tx_valid_q, tx_valid_n;
    logic [7:0]  tx_data_q, tx_data_n;
    logic        error_n, done_n;
    logic        fire, ack_ok, timeout, timer_clear;

    assign fire        = tx_valid_q && link.tx_ready;
    assign ack_ok      = link.rx_valid && (link.rx_data == UPDI_ACK);
    assign idx_inc     = idx + 8'd1;
    assign len_m1      = (len != 8'd0) ? len - 8'd1 : 8'd0;
    assign timer_clear = !((state == ST_PTR_ACK) || (state == ST_DATA_ACK));

    updi_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .tick    (1'b1),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= 2'd0;
            idx        <= 8'd0;
            len        <= 8'd0;
            addr       <= 16'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            error      <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            idx        <= idx_n;
            len        <= len_n;
            addr       <= addr_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
            error      <= error_n;
            done       <= done_n;
            ready      <= (state_n == ST_IDLE);
        end
    end

    always_comb begin
        state_n    = state;
        step_n     = step;
        idx_n      = idx;
        len_n      = len;
        addr_n     = addr;
        tx_valid_n = tx_valid_q;
        tx_data_n  = tx_data_q;
        error_n    = error;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_n   = block_length;
                    addr_n  = block_address;
                    idx_n   = 8'd0;
                    step_n  = 2'd0;
                    error_n = 1'b0;
                    if (block_type == BLOCK_TYPE_EOF) begin
                        state_n = ST_FINISH;
                    end else if (block_type != BLOCK_TYPE_DATA) begin
                        state_n = ST_FINISH;
                        error_n = 1'b1;
                    end else if (block_length == 8'd0) begin
                        state_n = ST_FINISH;
                    end else begin
                        state_n    = ST_PTR;
                        tx_valid_n = 1'b1;
                        tx_data_n  = UPDI_SYNCH;
                    end
                end
            end
            // In the multi-byte states the byte for step 0 is loaded on entry;
            // each transfer loads the byte for the following step.
            ST_PTR: begin
                if (fire) begin
                    step_n = step + 2'd1;
                    case (step)
                        2'd0:    tx_data_n = UPDI_ST_PTR_W;
                        2'd1:    tx_data_n = addr[7:0];
                        2'd2:    tx_data_n = addr[15:8];
                        default: begin
                            state_n    = ST_PTR_ACK;
                            tx_valid_n = 1'b0;
                            step_n     = 2'd0;
                        end
                    endcase
                end
            end
            ST_RPT: begin
                if (fire) begin
                    step_n = step + 2'd1;
                    case (step)
                        2'd0:    tx_data_n = UPDI_REPEAT_B;
                        2'd1:    tx_data_n = len_m1;
                        default: begin
                            state_n   = ST_ST;
                            tx_data_n = UPDI_SYNCH;
                            step_n    = 2'd0;
                        end
                    endcase
                end
            end
            ST_ST: begin
                if (fire) begin
                    step_n = step + 2'd1;
                    if (step == 2'd0) begin
                        tx_data_n = UPDI_ST_PTRINC_B;
                    end else begin
                        state_n   = ST_DATA;
                        tx_data_n = block_data[idx[DATA_BLOCK_ADDR_BITS-1:0]];
                        step_n    = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    state_n    = ST_DATA_ACK;
                    tx_valid_n = 1'b0;
                end
            end
            ST_PTR_ACK, ST_DATA_ACK: begin
                // A response arriving on the timeout cycle still counts as a response.
                if (link.rx_valid && !ack_ok) begin
                    state_n = ST_FINISH;
                    error_n = 1'b1;
                end else if (ack_ok && state == ST_PTR_ACK) begin
                    state_n    = ST_RPT;
                    tx_valid_n = 1'b1;
                    tx_data_n  = UPDI_SYNCH;
                end else if (ack_ok) begin
                    idx_n = idx_inc;
                    if (idx_inc == len) begin
                        state_n = ST_FINISH;
                    end else begin
                        state_n    = ST_DATA;
                        tx_valid_n = 1'b1;
                        tx_data_n  = block_data[idx_inc[DATA_BLOCK_ADDR_BITS-1:0]];
                    end
                end else if (timeout) begin
                    state_n = ST_FINISH;
                    error_n = 1'b1;
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign link.tx_valid = tx_valid_q;
    assign link.tx_data  = tx_data_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_updi_block_writer.sv
// Directed bench for updi_block_writer: a scoreboard of expected TX bytes,
// an ACK responder driven from a response plan, and latency/flag checks.
module tb_updi_block_writer;
    import updi_pkg::*;

    localparam int MAX = 8;
    localparam int TO  = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready, done, error;
    logic [7:0]  block_length = 8'd0;
    logic [15:0] block_address = 16'd0;
    logic [7:0]  block_type = 8'd0;
    logic [MAX-1:0][7:0] block_data = '0;
    updi_block_writer_state state_dbg;

    updi_block_writer_if link ();

    updi_block_writer #(
        .DATA_BLOCK_MAX_SIZE (MAX),
        .ACK_TIMEOUT         (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ready         (ready),
        .done          (done),
        .error         (error),
        .block_length  (block_length),
        .block_address (block_address),
        .block_type    (block_type),
        .block_data    (block_data),
        .link          (link.master),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // exp_q entries: {ack_follows, byte}; resp_q entries: {respond, byte}
    logic [8:0] exp_q[$];
    logic [8:0] resp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int mode = 1;
    int pend = 0;
    logic pend_valid = 1'b0;
    logic [7:0] pend_data = 8'h00;
    logic hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    int done_cnt = 0;
    int done_cyc = 0;
    int req_cyc = 0;
    int start_cyc = 0;
    int bytes_sent = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        logic [8:0] e;
        logic [8:0] r;
        @(negedge clk);
        cyc++;
        case (mode)
            0:       link.tx_ready = 1'b0;
            1:       link.tx_ready = 1'b1;
            default: link.tx_ready = 1'($urandom_range(0, 1));
        endcase
        link.rx_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0 && pend_valid) begin
                link.rx_valid = 1'b1;
                link.rx_data  = pend_data;
            end
        end
        if (hold_pend) check("tx_hold", {link.tx_valid, link.tx_data}, {1'b1, hold_data});
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (link.tx_valid === 1'b1 && link.tx_ready) begin
            bytes_sent++;
            total_cnt++;
            assert (exp_q.size() > 0) pass_cnt++;
            else $error("FAIL tx_extra observed=%02h required=none", link.tx_data);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_byte", link.tx_data, e[7:0]);
                if (e[8]) begin
                    req_cyc = cyc;
                    check("resp_plan", resp_q.size() > 0, 1);
                    if (resp_q.size() > 0) begin
                        r = resp_q.pop_front();
                        pend       = 2;
                        pend_valid = r[8];
                        pend_data  = r[7:0];
                    end
                end
            end
        end
        hold_pend = (link.tx_valid === 1'b1) && !link.tx_ready;
        hold_data = link.tx_data;
    endtask

    task automatic push_stream(input logic [15:0] addr, input logic [7:0] len,
                               input int n_data, input bit ptr_only);
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'h69});
        exp_q.push_back({1'b0, addr[7:0]});
        exp_q.push_back({1'b1, addr[15:8]});
        if (!ptr_only) begin
            exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'hA0});
            exp_q.push_back({1'b0, 8'(len - 8'd1)});
            exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'h64});
            for (int k = 0; k < n_data; k++) exp_q.push_back({1'b1, block_data[k % MAX]});
        end
    endtask

    task automatic push_acks(input int n);
        for (int k = 0; k < n; k++) resp_q.push_back({1'b1, 8'h40});
    endtask

    task automatic do_start(input logic [15:0] addr, input logic [7:0] len,
                            input logic [7:0] typ, input bit expect_tx);
        block_address = addr;
        block_length  = len;
        block_type    = typ;
        check("ready_before_start", ready, 1);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        if (expect_tx) check("first_tx_valid", link.tx_valid, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
        check("ready_with_done", ready, 1);
        tick();
        check("done_one_cycle", done, 0);
        tick();
        check("single_done", done_cnt - d0, 1);
    endtask

    initial begin
        int b0;
        int n;
        link.tx_ready = 1'b0;
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
        for (int k = 0; k < MAX; k++) block_data[k] = 8'($urandom_range(0, 255));
        block_data[0] = 8'h11;
        block_data[1] = 8'h22;
        block_data[2] = 8'h33;

        // reset values
        tick();
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_tx_valid", link.tx_valid, 0);
        check("rst_tx_data", link.tx_data, 8'h00);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        check("ready_after_rst", ready, 1);

        // basic block, tx_ready held high
        mode = 1;
        push_stream(16'h8100, 8'd3, 3, 1'b0);
        push_acks(4);
        do_start(16'h8100, 8'd3, 8'h00, 1'b1);
        wait_done(200);
        check("basic_error", error, 0);
        check("basic_stream_left", exp_q.size(), 0);
        check("basic_resp_left", resp_q.size(), 0);

        // same block with random tx_ready and a start pulse while busy
        mode = 2;
        push_stream(16'h8100, 8'd3, 3, 1'b0);
        push_acks(4);
        do_start(16'h8100, 8'd3, 8'h00, 1'b1);
        repeat (5) tick();
        block_type   = 8'h01;
        block_length = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        block_type   = 8'h00;
        block_length = 8'd3;
        wait_done(400);
        check("rand_error", error, 0);
        check("rand_stream_left", exp_q.size(), 0);

        // NACK on the second data byte
        mode = 1;
        push_stream(16'h8100, 8'd3, 2, 1'b0);
        resp_q.push_back({1'b1, 8'h40});
        resp_q.push_back({1'b1, 8'h40});
        resp_q.push_back({1'b1, 8'h00});
        do_start(16'h8100, 8'd3, 8'h00, 1'b1);
        wait_done(200);
        check("nack_error", error, 1);
        repeat (10) tick();
        check("nack_stream_left", exp_q.size(), 0);
        check("nack_error_sticky", error, 1);

        // end-of-file block: no bytes, done two cycles after start, error cleared
        do_start(16'h0000, 8'd5, 8'h01, 1'b0);
        wait_done(10);
        check("eof_latency", done_cyc - start_cyc, 2);
        check("eof_error", error, 0);

        // zero-length data block
        do_start(16'h1234, 8'd0, 8'h00, 1'b0);
        wait_done(10);
        check("len0_latency", done_cyc - start_cyc, 2);
        check("len0_error", error, 0);

        // stray response while idle is ignored
        pend = 1;
        pend_valid = 1'b1;
        pend_data = 8'h00;
        repeat (3) tick();
        check("idle_rx_error", error, 0);
        check("idle_rx_ready", ready, 1);

        // unsupported block type
        do_start(16'h1234, 8'd2, 8'h07, 1'b0);
        wait_done(10);
        check("badtype_latency", done_cyc - start_cyc, 2);
        check("badtype_error", error, 1);

        // no ACK after PTR
        push_stream(16'h1234, 8'd4, 0, 1'b1);
        resp_q.push_back({1'b0, 8'h00});
        do_start(16'h1234, 8'd4, 8'h00, 1'b1);
        wait_done(TO + 50);
        check("timeout_cycles", done_cyc - req_cyc - 2, TO);
        check("timeout_error", error, 1);
        check("timeout_stream_left", exp_q.size(), 0);

        // reset while the second data byte is waiting on tx_ready
        push_stream(16'h8100, 8'd3, 3, 1'b0);
        push_acks(4);
        b0 = bytes_sent;
        do_start(16'h8100, 8'd3, 8'h00, 1'b1);
        n = 0;
        while (bytes_sent < b0 + 10 && n < 100) begin
            tick();
            n++;
        end
        check("reached_data0", bytes_sent - b0, 10);
        mode = 0;
        n = 0;
        tick();
        while (link.tx_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("held_data1", {link.tx_valid, link.tx_data}, {1'b1, 8'h22});
        b0 = done_cnt;
        exp_q.delete();
        resp_q.delete();
        pend = 0;
        hold_pend = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_tx_valid", link.tx_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 0);
        rst = 1'b0;
        tick();
        check("postrst_ready", ready, 1);
        check("postrst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("postrst_no_done", done_cnt - b0, 0);
        check("postrst_error", error, 0);

        // clean run after reset
        mode = 1;
        push_stream(16'h4002, 8'd3, 3, 1'b0);
        push_acks(4);
        do_start(16'h4002, 8'd3, 8'h00, 1'b1);
        wait_done(200);
        check("clean_error", error, 0);
        check("clean_stream_left", exp_q.size(), 0);

        // length beyond the storage wraps the data index
        for (int k = 0; k < MAX; k++) block_data[k] = 8'(8'hC0 + k);
        mode = 2;
        push_stream(16'h0010, 8'd10, 10, 1'b0);
        push_acks(11);
        do_start(16'h0010, 8'd10, 8'h00, 1'b1);
        wait_done(600);
        check("wrap_error", error, 0);
        check("wrap_stream_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
